// File: rtl/keccak_pi_engine_if.sv
// Bus bundle between the round controller / state RAM side (master) and the
// slice-serial Keccak pi engine (slave).
interface keccak_pi_engine_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] src_base;
  logic [ADDR_W-1:0] dst_base;
  logic [0:24]       mem_rdata;
  logic [ADDR_W-1:0] mem_adr;
  logic              mem_rd;
  logic              mem_wr;
  logic [0:24]       mem_wdata;
  logic              busy;
  logic              done;

  modport master (
    output start, mode, src_base, dst_base, mem_rdata,
    input  mem_adr, mem_rd, mem_wr, mem_wdata, busy, done
  );

  modport slave (
    input  start, mode, src_base, dst_base, mem_rdata,
    output mem_adr, mem_rd, mem_wr, mem_wdata, busy, done
  );
endinterface

// File: rtl/keccak_pi_engine.sv
// Slice-serial Keccak pi engine: read slice, permute its 25 lanes, write to the
// destination block. Define KECCAK_PI_INVERSE_EN to build the inverse-pi path.
module keccak_pi_engine #(
  parameter int SLICES = 64,
  parameter int ADDR_W = 6,
  parameter int RD_LAT = 1
) (
  input  logic         clock,
  input  logic         reset,
  keccak_pi_engine_if.slave bus
);
  localparam int K_W  = $clog2(SLICES + 1);
  localparam int WT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [K_W-1:0]  K_LAST  = K_W'(SLICES - 1);
  localparam logic [WT_W-1:0] WT_LAST = WT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {IDLE, RD, WT, WR, FIN} state_t;

  state_t            state, state_nxt;
  logic [K_W-1:0]    k, k_nxt;
  logic [WT_W-1:0]   wt_cnt, wt_cnt_nxt;
  logic [ADDR_W-1:0] src_q, dst_q, src_sel;
  logic [ADDR_W-1:0] adr_q, adr_nxt;
  logic              rd_q, rd_nxt, wr_q, wr_nxt;
  logic              busy_q, busy_nxt, done_q, done_nxt;
  logic [0:24]       wdata_q, perm;
  logic              capture;

  function automatic logic [0:24] pi_fwd(input logic [0:24] din);
    logic [0:24] dout;
    logic [4:0]  dst;
    dout = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        dst = 5'(5 * ((2 * c + 3 * r + 2) % 5) + r);
        dout[dst] = din[5*r+c];
      end
    end
    return dout;
  endfunction

`ifdef KECCAK_PI_INVERSE_EN
  logic mode_q;

  function automatic logic [0:24] pi_inv(input logic [0:24] din);
    logic [0:24] dout;
    logic [4:0]  src;
    dout = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        src = 5'(5 * ((2 * c + 3 * r + 2) % 5) + r);
        dout[5*r+c] = din[src];
      end
    end
    return dout;
  endfunction

  assign perm = mode_q ? pi_inv(bus.mem_rdata) : pi_fwd(bus.mem_rdata);
`else
  wire unused_mode = bus.mode;
  assign perm = pi_fwd(bus.mem_rdata);
`endif

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    k_nxt      = k;
    wt_cnt_nxt = wt_cnt;
    unique case (state)
      IDLE: if (bus.start) begin
        state_nxt = RD;
        k_nxt     = '0;
      end
      RD: begin
        state_nxt  = WT;
        wt_cnt_nxt = '0;
      end
      WT: if (wt_cnt == WT_LAST) state_nxt = WR;
          else wt_cnt_nxt = wt_cnt + 1'b1;
      WR: if (k == K_LAST) state_nxt = FIN;
          else begin
            state_nxt = RD;
            k_nxt     = k + 1'b1;
          end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    src_sel  = (state == IDLE) ? bus.src_base : src_q;
    adr_nxt  = adr_q;
    rd_nxt   = 1'b0;
    wr_nxt   = 1'b0;
    if (state_nxt == RD) begin
      adr_nxt = src_sel + ADDR_W'(k_nxt);
      rd_nxt  = 1'b1;
    end else if (state_nxt == WR) begin
      adr_nxt = dst_q + ADDR_W'(k_nxt);
      wr_nxt  = 1'b1;
    end
    busy_nxt = (state_nxt == RD) || (state_nxt == WT) || (state_nxt == WR);
    done_nxt = (state_nxt == FIN);
    capture  = (state == WT) && (wt_cnt == WT_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      k       <= '0;
      wt_cnt  <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      adr_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef KECCAK_PI_INVERSE_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      k      <= k_nxt;
      wt_cnt <= wt_cnt_nxt;
      adr_q  <= adr_nxt;
      rd_q   <= rd_nxt;
      wr_q   <= wr_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      if (state == IDLE && bus.start) begin
        src_q  <= bus.src_base;
        dst_q  <= bus.dst_base;
`ifdef KECCAK_PI_INVERSE_EN
        mode_q <= bus.mode;
`endif
      end
      if (capture) wdata_q <= perm;
    end
  end

  assign bus.mem_adr   = adr_q;
  assign bus.mem_rd    = rd_q;
  assign bus.mem_wr    = wr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_keccak_pi_engine.sv
// Directed bench for keccak_pi_engine: three instances cover default timing,
// a 7-bit address space, and a 3-cycle read latency with mid-job reset.
module tb_keccak_pi_engine;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset0, reset1, reset2;
  logic load0 = 1'b0, load1 = 1'b0, load2 = 1'b0;
  int   n_assert = 0, n_fail = 0;
  int   cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

`ifdef KECCAK_PI_INVERSE_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  keccak_pi_engine_if #(.ADDR_W(6)) bus0 ();
  keccak_pi_engine_if #(.ADDR_W(5)) bus1 ();
  keccak_pi_engine_if #(.ADDR_W(7)) bus2 ();

  keccak_pi_engine #(.SLICES(64), .ADDR_W(6), .RD_LAT(1)) dut0 (.clock(clock), .reset(reset0), .bus(bus0));
  keccak_pi_engine #(.SLICES(16), .ADDR_W(5), .RD_LAT(3)) dut1 (.clock(clock), .reset(reset1), .bus(bus1));
  keccak_pi_engine #(.SLICES(64), .ADDR_W(7), .RD_LAT(1)) dut2 (.clock(clock), .reset(reset2), .bus(bus2));

  // Memory models; images are copied in whole when the matching load flag is set.
  logic [0:24] mem0 [64], img0 [64], orig0 [64];
  logic [0:24] mem1 [32], img1 [32], orig1 [32];
  logic [0:24] mem2 [128], img2 [128], orig2 [64];
  logic [0:24] pipe1 [3];

  always @(posedge clock) begin
    if (load0) mem0 <= img0;
    else if (bus0.mem_wr) mem0[bus0.mem_adr] <= bus0.mem_wdata;
    bus0.mem_rdata <= bus0.mem_rd ? mem0[bus0.mem_adr] : '0;
  end

  // Read data exists only in the RD_LAT-th cycle after the read; zero otherwise.
  always @(posedge clock) begin
    if (load1) mem1 <= img1;
    else if (bus1.mem_wr) mem1[bus1.mem_adr] <= bus1.mem_wdata;
    pipe1[0] <= bus1.mem_rd ? mem1[bus1.mem_adr] : '0;
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign bus1.mem_rdata = pipe1[2];

  always @(posedge clock) begin
    if (load2) mem2 <= img2;
    else if (bus2.mem_wr) mem2[bus2.mem_adr] <= bus2.mem_wdata;
    bus2.mem_rdata <= bus2.mem_rd ? mem2[bus2.mem_adr] : '0;
  end

  int wr_cnt [3] = '{0, 0, 0};
  int rd_cnt [3] = '{0, 0, 0};
  int ovl_cnt [3] = '{0, 0, 0};
  int done_cnt [3] = '{0, 0, 0};
  int done_cyc [3] = '{0, 0, 0};
  int last_wr_cyc [3] = '{0, 0, 0};
  int wr_adr0 [$];
  int wr_adr1 [$];
  int wr_cyc1 [$];

  always @(negedge clock) begin
    if (bus0.mem_wr) begin
      wr_cnt[0]++;
      last_wr_cyc[0] = cyc;
      wr_adr0.push_back(int'(bus0.mem_adr));
    end
    if (bus0.mem_rd) rd_cnt[0]++;
    if (bus0.mem_rd && bus0.mem_wr) ovl_cnt[0]++;
    if (bus0.done) begin
      done_cnt[0]++;
      done_cyc[0] = cyc;
    end
    if (bus1.mem_wr) begin
      wr_cnt[1]++;
      wr_adr1.push_back(int'(bus1.mem_adr));
      wr_cyc1.push_back(cyc);
    end
    if (bus1.mem_rd) rd_cnt[1]++;
    if (bus1.mem_rd && bus1.mem_wr) ovl_cnt[1]++;
    if (bus1.done) done_cnt[1]++;
    if (bus2.mem_wr) wr_cnt[2]++;
    if (bus2.mem_rd) rd_cnt[2]++;
    if (bus2.mem_rd && bus2.mem_wr) ovl_cnt[2]++;
    if (bus2.done) done_cnt[2]++;
  end

  // Reference map written out by hand: input bit i lands on output bit fwd_map[i].
  int fwd_map [25] = '{10, 20, 5, 15, 0, 1, 11, 21, 6, 16, 17, 2, 12, 22, 7,
                       8, 18, 3, 13, 23, 24, 9, 19, 4, 14};

  function automatic logic [0:24] model_fwd(input logic [0:24] din);
    logic [0:24] d;
    d = '0;
    for (int i = 0; i < 25; i++) d[fwd_map[i]] = din[i];
    return d;
  endfunction

  function automatic logic [0:24] model_inv(input logic [0:24] din);
    logic [0:24] d;
    d = '0;
    for (int i = 0; i < 25; i++) d[i] = din[fwd_map[i]];
    return d;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic drive_start(input int w, input logic v, input logic m, input int s, input int d);
    case (w)
      0: begin bus0.start = v; bus0.mode = m; bus0.src_base = 6'(s); bus0.dst_base = 6'(d); end
      1: begin bus1.start = v; bus1.mode = m; bus1.src_base = 5'(s); bus1.dst_base = 5'(d); end
      default: begin bus2.start = v; bus2.mode = m; bus2.src_base = 7'(s); bus2.dst_base = 7'(d); end
    endcase
  endtask

  task automatic start_job(input int w, input logic m, input int s, input int d, output int t0);
    drive_start(w, 1'b1, m, s, d);
    tick();
    t0 = cyc;
    drive_start(w, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic wait_done(input int w, input int budget, input string tag);
    int d0, i;
    d0 = done_cnt[w];
    i = 0;
    while (done_cnt[w] == d0 && i < budget) begin
      tick();
      i++;
    end
    check(tag, done_cnt[w] - d0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, errs, qb, w_snap, r_snap, d_snap, i;
    logic [0:24] hot, exp10, e;
    hot = '0;   hot[0] = 1'b1;
    exp10 = '0; exp10[10] = 1'b1;
    reset0 = 1'b1; reset1 = 1'b1; reset2 = 1'b1;
    for (int w = 0; w < 3; w++) drive_start(w, 1'b0, 1'b0, 0, 0);
    repeat (3) tick();
    reset0 = 1'b0; reset1 = 1'b0; reset2 = 1'b0;
    repeat (5) tick();
    check("rst_adr", bus0.mem_adr, 0);
    check("rst_rd", bus0.mem_rd, 0);
    check("rst_wr", bus0.mem_wr, 0);
    check("rst_wdata", bus0.mem_wdata, 0);
    check("rst_busy", bus0.busy, 0);
    check("rst_done", bus0.done, 0);

    // One-hot slices in place: every written word holds only bit 10.
    for (int k = 0; k < 64; k++) img0[k] = hot;
    load0 = 1'b1; tick(); load0 = 1'b0;
    w_snap = wr_cnt[0];
    start_job(0, 1'b0, 0, 0, t0);
    check("t1_first_rd", bus0.mem_rd, 1);
    check("t1_first_adr", bus0.mem_adr, 0);
    check("t1_busy", bus0.busy, 1);
    wait_done(0, 400, "t1_done_seen");
    // Sampled cycle index is one below the cycle numbering counted from start.
    check("t1_done_cyc", done_cyc[0] - t0, 192);
    check("t1_last_wr_cyc", last_wr_cyc[0] - t0, 191);
    check("t1_busy_at_done", bus0.busy, 0);
    check("t1_writes", wr_cnt[0] - w_snap, 64);
    errs = 0;
    for (int k = 0; k < 64; k++) if (mem0[k] !== exp10) errs++;
    check("t1_mem_onehot", errs, 0);
    check("t1_mem63", mem0[63], exp10);

    // Start held through FIN is ignored there and taken on the next IDLE cycle.
    for (int k = 0; k < 64; k++) begin
      orig0[k] = 25'($urandom);
      img0[k]  = orig0[k];
    end
    load0 = 1'b1;
    drive_start(0, 1'b1, 1'b0, 0, 0);
    tick();
    load0 = 1'b0;
    check("t3_fin_start_ignored", bus0.mem_rd, 0);
    check("t1_done_one_cycle", bus0.done, 0);
    tick();
    t0 = cyc;
    drive_start(0, 1'b0, 1'b0, 0, 0);
    check("t3_b2b_accept", bus0.mem_rd, 1);
    wait_done(0, 400, "t3_fwd_done");
    tick();
    start_job(0, 1'b1, 0, 0, t0);
    wait_done(0, 400, "t3_inv_done");
    errs = 0;
    for (int k = 0; k < 64; k++) begin
      e = INV_EN ? orig0[k] : model_fwd(model_fwd(orig0[k]));
      if (mem0[k] !== e) errs++;
    end
    check("t3_roundtrip", errs, 0);

    // Block starting at 60 wraps through the top of a 64-word space.
    tick();
    for (int k = 0; k < 64; k++) begin
      orig0[k] = 25'($urandom);
      img0[k]  = orig0[k];
    end
    load0 = 1'b1; tick(); load0 = 1'b0;
    qb = wr_adr0.size();
    w_snap = wr_cnt[0];
    start_job(0, 1'b0, 60, 60, t0);
    check("t4_first_rd_adr", bus0.mem_adr, 60);
    wait_done(0, 400, "t4_done");
    check("t4_writes", wr_cnt[0] - w_snap, 64);
    errs = 0;
    for (int n = 0; n < 64; n++) if (wr_adr0[qb+n] != (60 + n) % 64) errs++;
    check("t4_wr_adr_seq", errs, 0);
    check("t4_wr_adr_after_wrap", wr_adr0[qb+4], 0);
    errs = 0;
    for (int a = 0; a < 64; a++) if (mem0[a] !== model_fwd(orig0[a])) errs++;
    check("t4_mem", errs, 0);

    // Random forward job from block 0 into block 64 of a 128-word space.
    for (int k = 0; k < 128; k++) begin
      if (k < 64) orig2[k] = 25'($urandom);
      img2[k] = (k < 64) ? orig2[k] : '0;
    end
    load2 = 1'b1; tick(); load2 = 1'b0;
    start_job(2, 1'b0, 0, 64, t0);
    wait_done(2, 400, "t2_done");
    errs = 0;
    for (int k = 0; k < 64; k++) if (mem2[64+k] !== model_fwd(orig2[k])) errs++;
    check("t2_dst", errs, 0);
    errs = 0;
    for (int k = 0; k < 64; k++) if (mem2[k] !== orig2[k]) errs++;
    check("t2_src_untouched", errs, 0);
    tick();
    start_job(2, 1'b1, 0, 64, t0);
    wait_done(2, 400, "t2_mode1_done");
    errs = 0;
    for (int k = 0; k < 64; k++) begin
      e = INV_EN ? model_inv(orig2[k]) : model_fwd(orig2[k]);
      if (mem2[64+k] !== e) errs++;
    end
    check("t2_mode1_dst", errs, 0);

    // Three-cycle read latency, with a stray start partway through the job.
    for (int k = 0; k < 32; k++) begin
      orig1[k] = (k < 16) ? (25'($urandom) | 25'd1) : '0;
      img1[k]  = orig1[k];
    end
    load1 = 1'b1; tick(); load1 = 1'b0;
    qb = wr_cyc1.size();
    w_snap = wr_cnt[1];
    d_snap = done_cnt[1];
    start_job(1, 1'b0, 0, 16, t0);
    repeat (20) tick();
    drive_start(1, 1'b1, 1'b1, 7, 3);
    tick();
    drive_start(1, 1'b0, 1'b0, 0, 0);
    wait_done(1, 200, "t5_done");
    check("t5_first_wr_cyc", wr_cyc1[qb] - t0, 4);
    check("t5_period", wr_cyc1[qb+1] - wr_cyc1[qb], 5);
    check("t5_first_wr_adr", wr_adr1[qb], 16);
    errs = 0;
    for (int k = 0; k < 16; k++) if (mem1[16+k] !== model_fwd(orig1[k])) errs++;
    check("t5_mem", errs, 0);
    repeat (10) tick();
    check("t5_writes", wr_cnt[1] - w_snap, 16);
    check("t5_single_done", done_cnt[1] - d_snap, 1);

    // Reset during the first wait cycle of slice 10.
    w_snap = wr_cnt[1];
    r_snap = rd_cnt[1];
    d_snap = done_cnt[1];
    start_job(1, 1'b0, 0, 16, t0);
    i = 0;
    while (rd_cnt[1] - r_snap < 11 && i < 200) begin
      tick();
      i++;
    end
    check("t6_reach_slice10", rd_cnt[1] - r_snap, 11);
    tick();
    reset1 = 1'b1;
    #1;
    check("t6_rst_adr", bus1.mem_adr, 0);
    check("t6_rst_rd", bus1.mem_rd, 0);
    check("t6_rst_wr", bus1.mem_wr, 0);
    check("t6_rst_wdata", bus1.mem_wdata, 0);
    check("t6_rst_busy", bus1.busy, 0);
    check("t6_rst_done", bus1.done, 0);
    repeat (2) tick();
    reset1 = 1'b0;
    repeat (10) tick();
    check("t6_writes_before_abort", wr_cnt[1] - w_snap, 10);
    check("t6_no_done", done_cnt[1] - d_snap, 0);
    w_snap = wr_cnt[1];
    start_job(1, 1'b0, 0, 16, t0);
    check("t6_restart_rd", bus1.mem_rd, 1);
    check("t6_restart_adr", bus1.mem_adr, 0);
    wait_done(1, 200, "t6_restart_done");
    check("t6_restart_writes", wr_cnt[1] - w_snap, 16);
    errs = 0;
    for (int k = 0; k < 16; k++) if (mem1[16+k] !== model_fwd(orig1[k])) errs++;
    check("t6_mem", errs, 0);

    check("no_rd_wr_overlap", ovl_cnt[0] + ovl_cnt[1] + ovl_cnt[2], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
